mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one memory/bus port among four requesters (e.g. fetch, load/store, debug, DMA).
- Drives the 2-bit select of the team's 32-bit 4:1 datapath mux, which steers address, write data and control onto the shared port.
- Sequences each transaction with a valid/ready handshake toward memory and a one-cycle ack back to the winning requester.
- Supports abort on request withdrawal and a timeout that reports an error.

Parameters:
- TIMEOUT_CYC, 16, cycles in GRANT without mem_ready before forced completion with err; 0 disables timeout.
- CNT_W, 8, timeout counter width; TIMEOUT_CYC must be < 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; must be held until ack, or dropped to abort.
- mem_ready  input  1  shared port has accepted/completed the transfer this cycle.
- sel  output  2  mux select, index of the current owner.
- grant  output  4  one-hot owner indication, all-zero when not in GRANT.
- mem_valid  output  1  transfer presented on the shared port.
- ack  output  4  one-hot, one-cycle completion pulse to the owner.
- err  output  1  one-cycle pulse with ack when completion was forced by timeout.
- busy  output  1  high in GRANT and DONE.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state=IDLE, sel=0, grant=0, mem_valid=0, ack=0, err=0, busy=0, ptr=3, counter=0.
  - No ack is issued for an interrupted transfer.
- All outputs are registered and driven from the state and the owner register.
- FSM states: IDLE, GRANT, DONE.
- IDLE:
  - If req!=0 at the clock edge, pick the winner: first set bit in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Next cycle: state=GRANT, sel=winner, grant=1<<winner, mem_valid=1, busy=1, counter=0.
  - If req==0, stay in IDLE.
- GRANT, evaluated each edge in this priority order:
  1. mem_ready=1 -> DONE. ack[owner]=1, err=0. mem_valid and grant drop. ptr=owner. Completion wins even if req[owner] drops in the same cycle.
  2. req[owner]=0 -> IDLE (abort). No ack. ptr=owner. mem_valid and grant drop.
  3. TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 -> DONE with ack[owner]=1 and err=1. ptr=owner.
  4. Otherwise stay in GRANT; counter increments, saturating.
  - sel and grant are stable for the whole GRANT interval.
  - Requests from non-owners are ignored during GRANT.
- DONE:
  - Lasts exactly one cycle (ack/err high), then IDLE.
  - sel holds the owner value; grant=0; mem_valid=0.
  - The acked requester must deassert req during DONE. Its req is not sampled until IDLE.
- Latency:
  - req to mem_valid: 1 cycle.
  - mem_ready to ack: 1 cycle.
  - Minimum 3 cycles per transaction (IDLE, GRANT, DONE) when mem_ready arrives in the first GRANT cycle.
- Fairness: a continuously requesting requester waits at most 3 other transactions.
- Simultaneous requests in IDLE: resolved purely by the rotating pointer. After reset, requester 0 has highest priority.
- No combinational path from req or mem_ready to any output.

Test Plan:
- Reset, then req=4'b0001 and mem_ready=1 in the first GRANT cycle -> sel=0, grant=0001, mem_valid=1 for 1 cycle, then ack=0001 for 1 cycle, then IDLE; ptr=0.
- req=4'b1111 held, re-asserted after each ack, mem_ready always 1 -> grant order 0,1,2,3,0; each ack one-hot, one cycle wide; sel matches grant.
- req=4'b0100, mem_ready low for 5 cycles then high -> grant=0100 and mem_valid held 6 cycles, sel=2 stable; ack=0100 the cycle after mem_ready.
- TIMEOUT_CYC=16, req=4'b0010, mem_ready never asserted -> GRANT exactly 16 cycles, then ack=0010 with err=1 for one cycle; next grant goes to the next requester in rotation.
- req[3] granted, then dropped after 2 cycles with mem_ready=0 -> return to IDLE, no ack, ptr=3; a pending req[0] is granted next.
- rst_n pulled low mid-GRANT, asynchronously to clk -> mem_valid, grant, busy and sel go to 0 immediately; no ack; after release, requester 0 has priority.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the shared memory port.
// Four requesters, one transfer at a time, ack/err pulse on completion.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   req[3:0]     per-requester request, held until ack or dropped to abort
//   mem_ready    shared port accepted/completed the transfer
//   sel[1:0]     datapath mux select (current owner)
//   grant[3:0]   one-hot owner, zero outside GRANT
//   mem_valid    transfer presented on the shared port
//   ack[3:0]     one-cycle completion pulse to the owner
//   err          with ack when completion was forced by timeout
//   busy         high in GRANT and DONE
module mem_port_arbiter #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mem_ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       mem_valid,
    output logic [3:0] ack,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [1:0]         win;
    logic               found;
    logic [1:0]         idx;
    logic               to_hit;

    // Search starts just after the last owner, so the last owner
    // has lowest priority on the next arbitration.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign to_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    owner_d = win;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // Completion beats a same-cycle request drop.
                if (mem_ready) begin
                    state_d = DONE;
                    ptr_d   = owner_q;
                end else if (!req[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = owner_q;
                end else if (to_hit) begin
                    state_d = DONE;
                    ptr_d   = owner_q;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel       = owner_q;
    assign mem_valid = (state_q == GRANT);
    assign busy      = (state_q == GRANT) || (state_q == DONE);
    assign grant     = (state_q == GRANT) ? (4'b0001 << owner_q) : 4'b0000;
    assign ack       = (state_q == DONE) ? (4'b0001 << owner_q) : 4'b0000;
    assign err       = err_q;

endmodule
